dma_reader: RTL

//   Avalon-MM read master: fetches NUM_CHANNELS interleaved sample regions from SDRAM (layout produced by the mic

---
 rtl/dma_reader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_reader.sv
// dma_reader: Avalon-MM read master streaming NUM_CHANNELS interleaved SDRAM regions as channel-tagged words.
// Latency: a word sampled with AM_READDATAVALID appears on out_* after the next clock edge (registered FWFT FIFO).
// Backpressure: reads issue only while in-flight + buffered < FIFO_DEPTH, so out_ready low throttles AM_READ.
module dma_reader #(
  parameter int NUM_CHANNELS = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] AM_ADDR,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic [3:0]  AM_BYTEENABLE,
  output logic        AM_READ,
  input  logic        AM_WAITREQUEST,
  input  logic [31:0] AM_READDATA,
  input  logic        AM_READDATAVALID,
  input  logic        start,
  input  logic [31:0] start_address,
  input  logic [31:0] number_samples,
  output logic [31:0] out_data,
  output logic [2:0]  out_channel,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        FINISHED
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0]       LAST_CH = 3'(NUM_CHANNELS - 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PONE_C  = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       start_addr_q, start_addr_d;
  logic [31:0]       ns_q, ns_d;
  // Eight slots so the 3-bit channel index can never address past the array.
  logic [31:0]       base_q [8];
  logic [31:0]       base_d [8];
  logic [2:0]        ch_q, ch_d;
  logic [31:0]       idx_q, idx_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];
  logic [2:0]        pop_ch_q, pop_ch_d;
  logic [31:0]       pop_idx_q, pop_idx_d;

  logic [CNT_W:0]    occupancy;
  logic              credit;
  logic              accept;
  logic              rsp;
  logic              pop;

  // Handshake qualifiers; a response with nothing outstanding (e.g. after a reset abort) is dropped.
  always_comb begin
    occupancy = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
    credit    = occupancy < DEPTH_C;
    AM_READ   = (state_q == S_ISSUE) && credit;
    accept    = AM_READ && !AM_WAITREQUEST;
    rsp       = AM_READDATAVALID && (in_flight_q != '0);
    out_valid = fifo_cnt_q != '0;
    pop       = out_valid && out_ready;
  end

  // Output port drive: address only meaningful while requesting; stream tags come from the pop counters.
  always_comb begin
    AM_BURSTCOUNT = 3'd1;
    AM_BYTEENABLE = 4'hF;
    AM_ADDR       = AM_READ ? (base_q[ch_q] + {idx_q[29:0], 2'b00}) : 32'd0;
    out_data      = out_valid ? mem_q[rd_ptr_q] : 32'd0;
    out_channel   = pop_ch_q;
    out_last      = out_valid && (pop_ch_q == LAST_CH) && (pop_idx_q == ns_q - 32'd1);
    FINISHED      = state_q == S_FIN;
  end

  // Transfer FSM: latch parameters, precompute region bases, walk channels within each sample index.
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    ns_d         = ns_q;
    base_d       = base_q;
    ch_d         = ch_q;
    idx_d        = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_addr_d = start_address;
          ns_d         = number_samples;
          state_d      = (number_samples == 32'd0) ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: begin
        for (int i = 0; i < 8; i++) begin
          base_d[i] = (i < NUM_CHANNELS) ? (start_addr_q + 32'(i) * {ns_q[29:0], 2'b00}) : 32'd0;
        end
        ch_d    = 3'd0;
        idx_d   = 32'd0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) begin
          if (ch_q == LAST_CH) begin
            ch_d  = 3'd0;
            idx_d = idx_q + 32'd1;
            if (idx_q == ns_q - 32'd1) begin
              state_d = S_DRAIN;
            end
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if ((in_flight_q == '0) && (fifo_cnt_q == '0)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding-read counter, FIFO pointers/storage and the pop-side channel/index counters.
  always_comb begin
    in_flight_d = in_flight_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    pop_ch_d    = pop_ch_q;
    pop_idx_d   = pop_idx_q;

    unique case ({accept, rsp})
      2'b10:   in_flight_d = in_flight_q + ONE_C;
      2'b01:   in_flight_d = in_flight_q - ONE_C;
      default: in_flight_d = in_flight_q;
    endcase

    unique case ({rsp, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + ONE_C;
      2'b01:   fifo_cnt_d = fifo_cnt_q - ONE_C;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (rsp) begin
      mem_d[wr_ptr_q] = AM_READDATA;
      wr_ptr_d        = wr_ptr_q + PONE_C;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PONE_C;
    end

    if (state_q == S_SETUP) begin
      pop_ch_d  = 3'd0;
      pop_idx_d = 32'd0;
    end else if (pop) begin
      if (pop_ch_q == LAST_CH) begin
        pop_ch_d  = 3'd0;
        pop_idx_d = pop_idx_q + 32'd1;
      end else begin
        pop_ch_d = pop_ch_q + 3'd1;
      end
    end
  end

  // State registers with synchronous active-low reset; reset aborts any transfer in progress.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      start_addr_q <= 32'd0;
      ns_q         <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        base_q[i] <= 32'd0;
      end
      ch_q         <= 3'd0;
      idx_q        <= 32'd0;
      in_flight_q  <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
      pop_ch_q     <= 3'd0;
      pop_idx_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      ns_q         <= ns_d;
      base_q       <= base_d;
      ch_q         <= ch_d;
      idx_q        <= idx_d;
      in_flight_q  <= in_flight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      pop_ch_q     <= pop_ch_d;
      pop_idx_q    <= pop_idx_d;
    end
  end

endmodule
